// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   Shares one single-port synchronous RAM between an instruction read port
//   (I) and a data read/write port (D). Each access takes three cycles:
//   IDLE (sample and arbitrate), ISSUE (drive the RAM) and RESP (one-cycle ack
//   with read data). Requests that arrive outside IDLE are held by the
//   requester and are picked up in the next IDLE.
//
// Configuration macro:
//   MEM_ARB_ROUND_ROBIN_EN
//     defined   : conflicts go to the port that was not granted last.
//                 After reset the first conflict goes to D.
//     undefined : fixed priority. D always wins a conflict.
//
// Parameters:
//   ADDR_W   word-address width of the shared RAM (default 13)
//   DATA_W   RAM word width (default 32)
//
// Ports:
//   clk       in   single clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   i_req     in   instruction read request, held with i_addr until i_ack
//   i_addr    in   instruction read address
//   i_ack     out  one-cycle pulse, instruction access complete
//   i_rdata   out  instruction read data, zero unless i_ack=1
//   d_req     in   data request, held with d_we/d_addr/d_wdata until d_ack
//   d_we      in   1 = write, 0 = read
//   d_addr    in   data address
//   d_wdata   in   data write data
//   d_ack     out  one-cycle pulse, data access complete
//   d_rdata   out  data read data, zero unless d_ack=1
//   mem_we    out  RAM write enable, high only during ISSUE of a write
//   mem_addr  out  RAM address (registered)
//   mem_din   out  RAM write data (registered)
//   mem_dout  in   RAM read data, one-cycle latency, holds on write cycles
//   busy      out  high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,

  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,

  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,

  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_RESP  = 2'b10
  } state_t;

  state_t state;

  // Port owning the access currently in flight (1 = D, 0 = I).
  logic grant_d;

  // Combinational arbitration result, only consumed in IDLE.
  logic pick_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Port granted by the most recent access (1 = D, 0 = I). Reset to I so the
  // first conflict after reset is resolved in favour of D.
  logic last_grant;
`endif

  // Arbitration decision: returns 1 when D should own the next access.
  // A lone requester always wins; conflict resolution depends on the build.
  function automatic logic arb_pick_d(input logic req_i,
                                      input logic req_d,
                                      input logic prev_d);
    logic win_d;
    win_d = 1'b0;
    if (req_d && !req_i) begin
      win_d = 1'b1;
    end else if (req_d && req_i) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      win_d = ~prev_d;
`else
      win_d = 1'b1;
`endif
    end else begin
      win_d = 1'b0;
    end
    return win_d;
  endfunction

  // Choose the winner for a potential IDLE exit.
  always_comb begin
    pick_d = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    pick_d = arb_pick_d(i_req, d_req, last_grant);
`else
    pick_d = arb_pick_d(i_req, d_req, 1'b0);
`endif
  end

  // Main FSM; every output except the read-data gates is registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      grant_d  <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= {ADDR_W{1'b0}};
      mem_din  <= {DATA_W{1'b0}};
      i_ack    <= 1'b0;
      d_ack    <= 1'b0;
      busy     <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          i_ack <= 1'b0;
          d_ack <= 1'b0;
          if (i_req || d_req) begin
            // Capture the winner's request so the requester's inputs are
            // not needed again until the next access.
            state    <= ST_ISSUE;
            busy     <= 1'b1;
            grant_d  <= pick_d;
            mem_addr <= pick_d ? d_addr : i_addr;
            // The I port is read-only, so its accesses never write.
            mem_we   <= pick_d & d_we;
            mem_din  <= pick_d ? d_wdata : {DATA_W{1'b0}};
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant <= pick_d;
`endif
          end else begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            mem_we <= 1'b0;
          end
        end

        ST_ISSUE: begin
          // The RAM samples address/we on this edge; dropping we here gives
          // exactly one write edge per write access. Read data appears on
          // mem_dout during RESP, aligned with the ack raised here.
          state  <= ST_RESP;
          mem_we <= 1'b0;
          i_ack  <= ~grant_d;
          d_ack  <= grant_d;
        end

        ST_RESP: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          i_ack <= 1'b0;
          d_ack <= 1'b0;
        end

        default: begin
          state  <= ST_IDLE;
          busy   <= 1'b0;
          mem_we <= 1'b0;
          i_ack  <= 1'b0;
          d_ack  <= 1'b0;
        end
      endcase
    end
  end

  // Read data is the RAM output passed through, gated to zero outside the ack.
  assign i_rdata = i_ack ? mem_dout : {DATA_W{1'b0}};
  assign d_rdata = d_ack ? mem_dout : {DATA_W{1'b0}};

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter. Contains a behavioural single-port RAM
// with one-cycle registered read, a table of single accesses, a scoreboard
// queue popped on every ack, and hand-written sequences for conflicts,
// back-to-back accesses and reset during a write.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst_n;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;
  logic              busy;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_ack    (i_ack),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_ack    (d_ack),
    .d_rdata  (d_rdata),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout),
    .busy     (busy)
  );

  // Clock: period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM, preloaded while preload is high.
  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
  logic preload;

  // RAM model: write on we, otherwise registered read; output holds on writes.
  always @(posedge clk) begin
    if (preload) begin
      ram[13'h0010] <= 32'hDEADBEEF;
      ram[13'h0004] <= 32'h44440004;
      ram[13'h0008] <= 32'h88880008;
      ram[13'h0020] <= 32'h11112222;
      mem_dout      <= 32'h0;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_din;
    end else begin
      mem_dout <= ram[mem_addr];
    end
  end

  // Counters and check helper.
  int pass_cnt = 0;
  int total_cnt = 0;
  int we_cnt = 0;
  int ack_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Scoreboard entries.
  typedef struct {
    logic        is_d;
    logic        has_data;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  // Monitor: pops the scoreboard on every ack, checks rdata gating and counts
  // write-enable cycles.
  always @(negedge clk) begin
    exp_t e;
    if (mem_we) we_cnt++;
    if (!i_ack && i_rdata != 32'h0) check("i_rdata_gated", i_rdata, 32'h0);
    if (!d_ack && d_rdata != 32'h0) check("d_rdata_gated", d_rdata, 32'h0);
    if (i_ack && d_ack) check("dual_ack", 32'h1, 32'h0);
    if (i_ack || d_ack) begin
      ack_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_ack", 32'h1, 32'h0);
      end else begin
        e = exp_q.pop_front();
        check("ack_port", {31'h0, d_ack}, {31'h0, e.is_d});
        if (e.has_data) check("rdata", d_ack ? d_rdata : i_rdata, e.data);
      end
    end
  end

  // Table of single accesses.
  typedef struct {
    logic        is_d;
    logic        we;
    logic [12:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } vec_t;

  task automatic push_exp(input logic is_d, input logic has_data, input logic [31:0] data);
    exp_t e;
    e.is_d = is_d;
    e.has_data = has_data;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // One access on an idle arbiter: latency and write-pulse count are checked.
  task automatic do_access(input vec_t v);
    int n;
    int w0;
    logic got;
    @(posedge clk); #1;
    push_exp(v.is_d, ~v.we, v.rdata);
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
    w0 = we_cnt;
    n = 0;
    got = 1'b0;
    while (!got && n < 10) begin
      @(negedge clk);
      n++;
      got = v.is_d ? d_ack : i_ack;
    end
    check("latency", n, 3);
    @(posedge clk); #1;
    i_req = 1'b0;
    d_req = 1'b0;
    d_we  = 1'b0;
    check("we_pulses", we_cnt - w0, v.we ? 32'd1 : 32'd0);
  endtask

  vec_t vecs [9];
  int   ack_idx[$];

  initial begin
    int k;
    int i_left;
    int d_left;
    int low_cnt;
    int acks0;
    vec_t v;

    vecs[0] = '{1'b0, 1'b0, 13'h0010, 32'h0,        32'hDEADBEEF};
    vecs[1] = '{1'b1, 1'b1, 13'h1FFF, 32'h12345678, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 13'h1FFF, 32'h0,        32'h12345678};
    vecs[3] = '{1'b0, 1'b0, 13'h1FFF, 32'h0,        32'h12345678};
    vecs[4] = '{1'b1, 1'b1, 13'h0000, 32'hA5A50F0F, 32'h0};
    vecs[5] = '{1'b0, 1'b0, 13'h0000, 32'h0,        32'hA5A50F0F};
    vecs[6] = '{1'b1, 1'b0, 13'h0010, 32'h0,        32'hDEADBEEF};
    vecs[7] = '{1'b1, 1'b1, 13'h0010, 32'h00000000, 32'h0};
    vecs[8] = '{1'b0, 1'b0, 13'h0010, 32'h0,        32'h00000000};

    preload = 1'b1;
    i_req = 1'b0; i_addr = 13'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 13'h0; d_wdata = 32'h0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    // Reset state.
    #11;
    check("rst_mem_we",   {31'h0, mem_we}, 32'h0);
    check("rst_mem_addr", {19'h0, mem_addr}, 32'h0);
    check("rst_mem_din",  mem_din, 32'h0);
    check("rst_i_ack",    {31'h0, i_ack}, 32'h0);
    check("rst_d_ack",    {31'h0, d_ack}, 32'h0);
    check("rst_busy",     {31'h0, busy}, 32'h0);
    #10 preload = 1'b0;
    #10 rst_n = 1'b1;

    // Table-driven single accesses.
    for (int i = 0; i < 9; i++) do_access(vecs[i]);

    // Conflict: I read 0x0004 once, D read 0x0008 twice, both held.
    @(posedge clk); #1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    push_exp(1'b1, 1'b1, 32'h88880008);
    push_exp(1'b0, 1'b1, 32'h44440004);
    push_exp(1'b1, 1'b1, 32'h88880008);
`else
    push_exp(1'b1, 1'b1, 32'h88880008);
    push_exp(1'b1, 1'b1, 32'h88880008);
    push_exp(1'b0, 1'b1, 32'h44440004);
`endif
    i_req = 1'b1; i_addr = 13'h0004;
    d_req = 1'b1; d_we = 1'b0; d_addr = 13'h0008;
    i_left = 1; d_left = 2; k = 0;
    ack_idx.delete();
    while ((i_left > 0 || d_left > 0) && k < 20) begin
      @(negedge clk);
      k++;
      if (i_ack || d_ack) ack_idx.push_back(k);
      if (i_ack && i_left > 0) i_left--;
      if (d_ack && d_left > 0) d_left--;
      @(posedge clk); #1;
      if (i_left == 0) i_req = 1'b0;
      if (d_left == 0) d_req = 1'b0;
    end
    check("conf_ack_count", ack_idx.size(), 3);
    for (int i = 0; i < ack_idx.size(); i++) check("conf_ack_cycle", ack_idx[i], 3 * (i + 1));
    i_req = 1'b0; d_req = 1'b0;

    // Back-to-back: D read of 0x1FFF held across four accesses.
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) push_exp(1'b1, 1'b1, 32'h12345678);
    d_req = 1'b1; d_we = 1'b0; d_addr = 13'h1FFF;
    d_left = 4; k = 0; low_cnt = 0;
    ack_idx.delete();
    while (d_left > 0 && k < 30) begin
      @(negedge clk);
      k++;
      if (k >= 2 && !busy) low_cnt++;
      if (d_ack) begin
        ack_idx.push_back(k);
        d_left--;
      end
      @(posedge clk); #1;
      if (d_left == 0) d_req = 1'b0;
    end
    d_req = 1'b0;
    check("b2b_ack_count", ack_idx.size(), 4);
    for (int i = 0; i < ack_idx.size(); i++) check("b2b_ack_cycle", ack_idx[i], 3 * (i + 1));
    check("b2b_busy_low", low_cnt, 3);

    // Reset during ISSUE of a write to 0x0020.
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b1; d_addr = 13'h0020; d_wdata = 32'hAAAA5555;
    acks0 = ack_cnt;
    @(posedge clk); #2;
    check("issue_we", {31'h0, mem_we}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("abort_mem_we",   {31'h0, mem_we}, 32'h0);
    check("abort_busy",     {31'h0, busy}, 32'h0);
    check("abort_mem_addr", {19'h0, mem_addr}, 32'h0);
    check("abort_mem_din",  mem_din, 32'h0);
    d_req = 1'b0; d_we = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_no_ack", ack_cnt - acks0, 32'h0);
    check("abort_ram_kept", ram[13'h0020], 32'h11112222);

    // First access after reset release.
    v = '{1'b1, 1'b0, 13'h0020, 32'h0, 32'h11112222};
    do_access(v);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Global bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1);
  end

endmodule
